// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer:
// FSM states, ALU operations and the opcode/funct7 values the decoder recognises.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALT      = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        XOR  = 4'd2,
        OR   = 4'd3,
        AND  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder for OP-IMM and OP: register addresses,
// immediate, ALU operation, operand source and an illegal-encoding flag.
module cpu_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] imm,
    output logic            alu_src_imm,
    output logic [3:0]      alu_op,
    output logic            illegal
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    alu_op_t    alu_op_s;
    logic       src_imm_s;
    logic       illegal_s;
    logic       shamt_imm_s;

    assign opcode_s = ir[6:0];
    assign funct3_s = ir[14:12];
    assign funct7_s = ir[31:25];

    assign rs1_addr    = ir[19:15];
    assign rs2_addr    = ir[24:20];
    assign rd_addr     = ir[11:7];
    assign alu_op      = alu_op_s;
    assign alu_src_imm = src_imm_s;
    assign illegal     = illegal_s;

    // Immediate shifts carry a zero-extended shamt instead of a signed constant.
    assign imm = shamt_imm_s ? {{(XLEN-5){1'b0}}, ir[24:20]}
                             : {{(XLEN-12){ir[31]}}, ir[31:20]};

    // Opcode/funct3/funct7 decode into ALU operation and legality.
    always_comb begin
        alu_op_s    = ADD;
        src_imm_s   = 1'b0;
        illegal_s   = 1'b0;
        shamt_imm_s = 1'b0;
        case (opcode_s)
            OPC_OP_IMM: begin
                src_imm_s = 1'b1;
                case (funct3_s)
                    3'b000:  alu_op_s = ADD;
                    3'b010:  alu_op_s = SLT;
                    3'b011:  alu_op_s = SLTU;
                    3'b100:  alu_op_s = XOR;
                    3'b110:  alu_op_s = OR;
                    3'b111:  alu_op_s = AND;
                    3'b001: begin
                        shamt_imm_s = 1'b1;
                        alu_op_s    = SLL;
                        illegal_s   = (funct7_s != F7_BASE);
                    end
                    3'b101: begin
                        shamt_imm_s = 1'b1;
                        alu_op_s    = (funct7_s == F7_ALT) ? SRA : SRL;
                        illegal_s   = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_OP: begin
                case (funct3_s)
                    3'b000:  alu_op_s = (funct7_s == F7_ALT) ? SUB : ADD;
                    3'b001:  alu_op_s = SLL;
                    3'b010:  alu_op_s = SLT;
                    3'b011:  alu_op_s = SLTU;
                    3'b100:  alu_op_s = XOR;
                    3'b101:  alu_op_s = (funct7_s == F7_ALT) ? SRA : SRL;
                    3'b110:  alu_op_s = OR;
                    3'b111:  alu_op_s = AND;
                    default: alu_op_s = ADD;
                endcase
                // The alternate funct7 is only meaningful for ADD/SUB and SRL/SRA.
                illegal_s = !((funct7_s == F7_BASE) ||
                              ((funct7_s == F7_ALT) &&
                               ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
            end
            default: illegal_s = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the RV32I integer
// datapath, with fetch-timeout and illegal-instruction halting.
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] imm,
    output logic            alu_src_imm,
    output logic [3:0]      alu_op,
    output logic            opnd_load,
    output logic            alu_en,
    output logic            reg_write,
    output logic            pc_inc,
    output logic [2:0]      state,
    output logic            illegal,
    output logic            timeout,
    output logic            halted,
    output logic [XLEN-1:0] instret
);

    localparam logic [2:0] ST_FETCH     = 3'(FETCH);
    localparam logic [2:0] ST_DECODE    = 3'(DECODE);
    localparam logic [2:0] ST_EXECUTE   = 3'(EXECUTE);
    localparam logic [2:0] ST_WRITEBACK = 3'(WRITEBACK);
    localparam logic [2:0] ST_HALT      = 3'(HALT);

    localparam int              WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic              run_r;
    logic [31:0]       ir_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              illegal_r;
    logic              timeout_r;
    logic [XLEN-1:0]   instret_r;
    logic              dec_illegal_s;
    logic              fetch_active_s;

    cpu_decoder #(.XLEN(XLEN)) u_decoder (
        .ir          (ir_r),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rd_addr     (rd_addr),
        .imm         (imm),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .illegal     (dec_illegal_s)
    );

    // run_r holds the fetch request off until the first clock after reset release.
    assign fetch_active_s = (state_r == ST_FETCH) && run_r;

    assign imem_req  = fetch_active_s;
    assign opnd_load = (state_r == ST_DECODE);
    assign alu_en    = (state_r == ST_EXECUTE);
    assign pc_inc    = (state_r == ST_WRITEBACK);
    assign reg_write = (state_r == ST_WRITEBACK) && (rd_addr != 5'd0);
    assign halted    = (state_r == ST_HALT);
    assign state     = state_r;
    assign illegal   = illegal_r;
    assign timeout   = timeout_r;
    assign instret   = instret_r;

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (!run_r) begin
                    state_nxt_s = ST_FETCH;
                end else if (imem_ack) begin
                    state_nxt_s = ST_DECODE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_illegal_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE:   state_nxt_s = ST_WRITEBACK;
            ST_WRITEBACK: state_nxt_s = ST_FETCH;
            ST_HALT:      state_nxt_s = ST_HALT;
            default:      state_nxt_s = ST_HALT;
        endcase
    end

    // State register, instruction register and fetch wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            run_r      <= 1'b0;
            ir_r       <= 32'd0;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            run_r   <= 1'b1;
            if (fetch_active_s && imem_ack) begin
                ir_r <= imem_rdata;
            end
            if (fetch_active_s && !imem_ack) begin
                wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end
        end
    end

    // Sticky fault flags and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
            instret_r <= {XLEN{1'b0}};
        end else begin
            if ((state_r == ST_DECODE) && dec_illegal_s) begin
                illegal_r <= 1'b1;
            end
            if (fetch_active_s && !imem_ack && (wait_cnt_r == WAIT_LAST)) begin
                timeout_r <= 1'b1;
            end
            if (state_r == ST_WRITEBACK) begin
                instret_r <= instret_r + {{(XLEN-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed self-checking bench for cpu_control_fsm (MAX_WAIT=4 so the timeout
// boundary is reachable in a few cycles).
module tb_cpu_control_fsm;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic        alu_src_imm;
    logic [3:0]  alu_op;
    logic        opnd_load;
    logic        alu_en;
    logic        reg_write;
    logic        pc_inc;
    logic [2:0]  state;
    logic        illegal;
    logic        timeout;
    logic        halted;
    logic [31:0] instret;

    logic [4:0]  strb;
    int          checks;
    int          failures;
    int          rw_cnt;
    int          pc_cnt;
    int          exp_ret;

    cpu_control_fsm #(.XLEN(32), .MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rd_addr     (rd_addr),
        .imm         (imm),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .opnd_load   (opnd_load),
        .alu_en      (alu_en),
        .reg_write   (reg_write),
        .pc_inc      (pc_inc),
        .state       (state),
        .illegal     (illegal),
        .timeout     (timeout),
        .halted      (halted),
        .instret     (instret)
    );

    assign strb = {imem_req, opnd_load, alu_en, reg_write, pc_inc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe pulse monitor.
    initial begin
        rw_cnt = 0;
        pc_cnt = 0;
    end
    always @(posedge clk) begin
        if (reg_write === 1'b1) rw_cnt <= rw_cnt + 1;
        if (pc_inc === 1'b1)    pc_cnt <= pc_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench #1 after the edge of cycle 1 (first imem_req cycle).
    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        exp_ret    = 0;
        step();
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_strobes", 32'(strb), 32'd0);
        check_val("rst_instret", instret, 32'd0);
        check_val("rst_flags", {29'd0, illegal, timeout, halted}, 32'd0);
        step();
        rst_n = 1'b1;
        check_val("req_at_release", 32'(imem_req), 32'd0);
        step();
        check_val("req_cycle1", 32'(imem_req), 32'd1);
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ins, input logic [4:0] rd_e,
                             input logic [4:0] rs1_e, input logic [4:0] rs2_e,
                             input logic [31:0] imm_e, input logic [3:0] op_e, input logic src_e);
        int rw0;
        int pc0;
        rw0 = rw_cnt;
        pc0 = pc_cnt;
        imem_ack   = 1'b1;
        imem_rdata = ins;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        check_val({nm, "_dec_strb"}, 32'(strb), 32'b01000);
        check_val({nm, "_rd"}, 32'(rd_addr), 32'(rd_e));
        check_val({nm, "_rs1"}, 32'(rs1_addr), 32'(rs1_e));
        check_val({nm, "_rs2"}, 32'(rs2_addr), 32'(rs2_e));
        check_val({nm, "_imm"}, imm, imm_e);
        check_val({nm, "_aluop"}, 32'(alu_op), 32'(op_e));
        check_val({nm, "_srcimm"}, 32'(alu_src_imm), 32'(src_e));
        step();
        check_val({nm, "_exe_strb"}, 32'(strb), 32'b00100);
        step();
        check_val({nm, "_wb_strb"}, 32'(strb), {29'd0, 1'b0, (rd_e != 5'd0), 1'b1});
        check_val({nm, "_wb_instret"}, instret, 32'(exp_ret));
        step();
        exp_ret++;
        check_val({nm, "_next_strb"}, 32'(strb), 32'b10000);
        check_val({nm, "_instret"}, instret, 32'(exp_ret));
        check_val({nm, "_illegal"}, 32'(illegal), 32'd0);
        check_val({nm, "_rw_pulses"}, 32'(rw_cnt - rw0), (rd_e != 5'd0) ? 32'd1 : 32'd0);
        check_val({nm, "_pc_pulses"}, 32'(pc_cnt - pc0), 32'd1);
    endtask

    initial begin
        int rw0;
        int pc0;
        checks   = 0;
        failures = 0;

        // Straight-line instructions, back to back.
        do_reset();
        run_instr("addi", 32'h0226_8193, 5'd3, 5'd13, 5'd2, 32'd34, 4'd0, 1'b1);
        run_instr("srai", 32'h4020_d613, 5'd12, 5'd1, 5'd2, 32'd2, 4'd7, 1'b1);
        run_instr("slli", 32'h0094_9893, 5'd17, 5'd9, 5'd9, 32'd9, 4'd5, 1'b1);
        run_instr("srai1", 32'h401d_de13, 5'd28, 5'd27, 5'd1, 32'd1, 4'd7, 1'b1);
        run_instr("nop", 32'h0000_0013, 5'd0, 5'd0, 5'd0, 32'd0, 4'd0, 1'b1);
        run_instr("sub", 32'h4073_02b3, 5'd5, 5'd6, 5'd7, 32'h0000_0407, 4'd1, 1'b0);

        // Illegal SLLI with funct7=0100000 halts; later acks are ignored.
        rw0 = rw_cnt;
        pc0 = pc_cnt;
        imem_ack   = 1'b1;
        imem_rdata = 32'h4011_1093;
        step();
        imem_ack = 1'b0;
        check_val("ill_dec_strb", 32'(strb), 32'b01000);
        step();
        check_val("ill_state", 32'(state), 32'd4);
        check_val("ill_flags", {29'd0, illegal, timeout, halted}, 32'b101);
        check_val("ill_strb", 32'(strb), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0226_8193;
        for (int i = 0; i < 3; i++) step();
        imem_ack = 1'b0;
        check_val("ill_absorb_state", 32'(state), 32'd4);
        check_val("ill_absorb_strb", 32'(strb), 32'd0);
        check_val("ill_instret", instret, 32'(exp_ret));
        check_val("ill_rw_pulses", 32'(rw_cnt - rw0), 32'd0);
        check_val("ill_pc_pulses", 32'(pc_cnt - pc0), 32'd0);

        // Fetch stall: three idle cycles, ack in the fourth.
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check_val("stall_state_c4", 32'(state), 32'd0);
        check_val("stall_req_c4", 32'(imem_req), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0226_8193;
        step();
        imem_ack = 1'b0;
        check_val("stall_decode", 32'(state), 32'd1);
        check_val("stall_no_timeout", 32'(timeout), 32'd0);

        // Timeout: no ack for MAX_WAIT=4 fetch cycles.
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check_val("to_state_c4", 32'(state), 32'd0);
        check_val("to_flag_c4", 32'(timeout), 32'd0);
        step();
        check_val("to_state", 32'(state), 32'd4);
        check_val("to_flags", {29'd0, illegal, timeout, halted}, 32'b011);
        check_val("to_strb", 32'(strb), 32'd0);

        // Reset during EXECUTE aborts without writeback.
        do_reset();
        run_instr("addi_pre", 32'h0226_8193, 5'd3, 5'd13, 5'd2, 32'd34, 4'd0, 1'b1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0226_8193;
        step();
        imem_ack = 1'b0;
        step();
        check_val("abort_exec_strb", 32'(strb), 32'b00100);
        rw0 = rw_cnt;
        pc0 = pc_cnt;
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        check_val("abort_state", 32'(state), 32'd0);
        check_val("abort_strb", 32'(strb), 32'd0);
        check_val("abort_instret", instret, 32'(exp_ret));
        step();
        step();
        rst_n = 1'b1;
        step();
        check_val("abort_rw_pulses", 32'(rw_cnt - rw0), 32'd0);
        check_val("abort_pc_pulses", 32'(pc_cnt - pc0), 32'd0);
        check_val("abort_req_after", 32'(strb), 32'b10000);
        check_val("abort_instret_after", instret, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle sequencer for the single-issue RV32I integer datapath (register bank, ALU, PC register).
- Fetches each instruction from instruction memory using a req/ack handshake.
- Decodes OP-IMM (0010011) and OP (0110011) instructions, then steps through DECODE, EXECUTE and WRITEBACK, driving the datapath control strobes.
- Halts on illegal instructions or fetch timeout, and keeps a retired-instruction counter for bench/debug visibility.

Parameters:
XLEN, 32, datapath width; immediate and counter width.
MAX_WAIT, 255, maximum cycles FETCH waits for imem_ack before a timeout halt; must be ≥1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid this cycle; ignored unless imem_req=1
imem_rdata  in  32  fetched instruction word
rs1_addr  out  5  register bank read address, IR[19:15]
rs2_addr  out  5  register bank read address, IR[24:20]
rd_addr  out  5  writeback address, IR[11:7]
imm  out  XLEN  operand immediate: sign-extended IR[31:20]; shifts use zero-extended IR[24:20]
alu_src_imm  out  1  1 = ALU B operand is imm, 0 = rs2
alu_op  out  4  alu_op_t encoding
opnd_load  out  1  latch register-bank read data into operand registers
alu_en  out  1  latch ALU result
reg_write  out  1  register bank write strobe
pc_inc  out  1  PC += 4 strobe
state  out  3  current FSM state, for debug
illegal  out  1  sticky: an illegal instruction was decoded
timeout  out  1  sticky: FETCH exceeded MAX_WAIT
halted  out  1  FSM is in HALT
instret  out  XLEN  count of retired instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; IR=0; wait counter=0.
  - instret=0; illegal=timeout=0.
  - All strobes are 0, and imem_req=0 while rst_n=0.
  - imem_req rises combinationally from state one cycle after release.
- FETCH:
  - imem_req=1.
  - If imem_ack is high at a rising edge, IR<=imem_rdata and go to DECODE. An ack in the first cycle gives a 1-cycle FETCH.
  - Otherwise increment the wait counter. When wait counter == MAX_WAIT-1 with no ack, set timeout=1 and go to HALT.
  - The wait counter clears on entering FETCH.
- DECODE:
  - opnd_load=1 for exactly one cycle.
  - If decode is illegal: illegal<=1 and go to HALT. No reg_write, pc_inc or instret change occurs. Otherwise go to EXECUTE.
- EXECUTE: alu_en=1 for one cycle, then go to WRITEBACK.
- WRITEBACK:
  - reg_write=1 only if rd_addr != 0.
  - pc_inc=1; instret<=instret+1, wrapping mod 2^XLEN.
  - Next state is FETCH.
- HALT:
  - Absorbing; all strobes and imem_req are 0.
  - Exits only via reset.
- Latency: minimum 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK). Each wait cycle adds 1.
- Output timing: decode outputs (addresses, imm, alu_op, alu_src_imm) are combinational from IR and are stable from DECODE through WRITEBACK. Strobes are Moore outputs from state.
- Decode, keyed on funct3:
  - 000: ADD. On OP, funct7 0100000 selects SUB.
  - 100: XOR. 110: OR. 111: AND. 010: SLT. 011: SLTU.
  - 001: SLL. Requires funct7=0000000.
  - 101: SRL when funct7=0000000, SRA when funct7=0100000.
  - OP requires funct7 to be 0000000, or 0100000 only for ADD/SUB and SRL/SRA.
  - Any other opcode or funct7 combination is illegal.
- alu_src_imm is 1 for OP-IMM and 0 for OP.
- Reset mid-instruction aborts immediately: no partial writeback, and PC/instret are not advanced by the aborted instruction.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state_t enum: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4.
  - alu_op_t enum: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - Opcode constants OPC_OP_IMM and OPC_OP.
  - funct7 constants F7_BASE and F7_ALT.
- Sub-module cpu_decoder is purely combinational: IR in; alu_op, alu_src_imm, imm, addresses and illegal flag out.
- The FSM, wait counter and instret counter live in cpu_control_fsm.

Test Plan:
- Single ADDI: 0x02268193 (ADDI x3,x13,34) with ack in the first FETCH cycle.
  - Expect rd=3, rs1=13, imm=34, alu_op=ADD, alu_src_imm=1.
  - Expect one opnd_load, alu_en and reg_write/pc_inc pulse in cycles 2, 3 and 4 respectively; instret=1.
  - The next imem_req follows in cycle 5.
- Shift decode:
  - 0x4020d613 (SRAI x12,x1,2) -> alu_op=SRA, imm=2.
  - 0x00949893 (SLLI x17,x9,9) -> alu_op=SLL, imm=9.
  - 0x401dde13 -> SRA, imm=1.
  - Expect no illegal flag on any of them.
- Illegal instruction: 0x40111093 (SLLI with funct7=0100000).
  - Expect illegal=1 and halted=1 two cycles after ack.
  - Expect reg_write, pc_inc and instret unchanged.
  - Further acks are ignored until reset.
- rd=x0: 0x00000013 (NOP).
  - Expect reg_write stays 0, pc_inc pulses once, instret increments.
- Fetch stall and timeout:
  - Ack after 3 idle cycles -> FETCH held 4 cycles, DECODE follows.
  - With MAX_WAIT=4 and no ack -> timeout=1, halted=1 after exactly 4 FETCH cycles.
- Reset mid-instruction: assert rst_n=0 during EXECUTE of ADDI.
  - Expect state=FETCH immediately, strobes 0, instret=0, and no reg_write or pc_inc pulse.
